// File: rtl/conv_layer_sequencer.sv
// Streams weights/biases/input map into the conv engine RAMs, starts it, forwards results (1-cycle latency).
// Stream backpressure: s_ready high only while loading; output beats have no backpressure.
module conv_layer_sequencer #(
    parameter int INPUT_CHANNELS  = 1,
    parameter int OUTPUT_CHANNELS = 32,
    parameter int KERNEL_SIZE     = 3,
    parameter int INPUT_WIDTH     = 30,
    parameter int INPUT_HEIGHT    = 30,
    localparam int W_SIZE    = OUTPUT_CHANNELS * INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int I_SIZE    = INPUT_CHANNELS * INPUT_HEIGHT * INPUT_WIDTH,
    localparam int WA_W      = (W_SIZE > 1) ? $clog2(W_SIZE) : 1,
    localparam int BA_W      = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1,
    localparam int IA_W      = (I_SIZE > 1) ? $clog2(I_SIZE) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            layer_start,
    input  logic            cfg_load_params,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [7:0]      weight_data_in,
    output logic            weight_data_we,
    output logic [WA_W-1:0] weight_data_addr,
    output logic [31:0]     bias_data_in,
    output logic            bias_data_we,
    output logic [BA_W-1:0] bias_data_addr,
    output logic [7:0]      input_data_in,
    output logic            input_data_we,
    output logic [IA_W-1:0] input_data_addr,
    output logic            eng_start,
    input  logic            eng_done,
    input  logic [7:0]      eng_result,
    input  logic            eng_valid,
    output logic [7:0]      m_data,
    output logic            m_valid,
    output logic            layer_busy,
    output logic            layer_done,
    output logic            err_count
);

    localparam int B_BYTES   = 4 * OUTPUT_CHANNELS;
    localparam int OUT_COUNT = OUTPUT_CHANNELS * (INPUT_HEIGHT - KERNEL_SIZE + 1)
                             * (INPUT_WIDTH - KERNEL_SIZE + 1);
    localparam int MAX_BYTES = (W_SIZE > I_SIZE) ? ((W_SIZE > B_BYTES) ? W_SIZE : B_BYTES)
                                                 : ((I_SIZE > B_BYTES) ? I_SIZE : B_BYTES);
    // Two spare bits so the bias group index slice [BA_W+1:2] always exists.
    localparam int CNT_W  = $clog2(MAX_BYTES) + 2;
    localparam int BEAT_W = $clog2(OUT_COUNT + 1);

    localparam logic [CNT_W-1:0]  W_LAST    = CNT_W'(W_SIZE - 1);
    localparam logic [CNT_W-1:0]  B_LAST    = CNT_W'(B_BYTES - 1);
    localparam logic [CNT_W-1:0]  I_LAST    = CNT_W'(I_SIZE - 1);
    localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(OUT_COUNT);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_B, LOAD_I, START, RUN, FINISH
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    byte_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [31:0]         bias_sr;
    logic                eng_done_q;
    logic                accept;

    assign accept = s_valid && s_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            byte_cnt         <= '0;
            beat_cnt         <= '0;
            bias_sr          <= '0;
            eng_done_q       <= 1'b0;
            s_ready          <= 1'b0;
            weight_data_in   <= '0;
            weight_data_we   <= 1'b0;
            weight_data_addr <= '0;
            bias_data_in     <= '0;
            bias_data_we     <= 1'b0;
            bias_data_addr   <= '0;
            input_data_in    <= '0;
            input_data_we    <= 1'b0;
            input_data_addr  <= '0;
            eng_start        <= 1'b0;
            m_data           <= '0;
            m_valid          <= 1'b0;
            layer_busy       <= 1'b0;
            layer_done       <= 1'b0;
            err_count        <= 1'b0;
        end else begin
            weight_data_we <= 1'b0;
            bias_data_we   <= 1'b0;
            input_data_we  <= 1'b0;
            eng_start      <= 1'b0;
            layer_done     <= 1'b0;
            m_valid        <= 1'b0;
            eng_done_q     <= eng_done;

            case (state)
                IDLE: begin
                    if (layer_start) begin
                        layer_busy <= 1'b1;
                        s_ready    <= 1'b1;
                        byte_cnt   <= '0;
                        state      <= cfg_load_params ? LOAD_W : LOAD_I;
                    end
                end

                LOAD_W: begin
                    if (accept) begin
                        weight_data_we   <= 1'b1;
                        weight_data_addr <= byte_cnt[WA_W-1:0];
                        weight_data_in   <= s_data;
                        if (byte_cnt == W_LAST) begin
                            byte_cnt <= '0;
                            state    <= LOAD_B;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                LOAD_B: begin
                    if (accept) begin
                        // Shift in from the top so byte 0 of a group ends up in [7:0].
                        bias_sr <= {s_data, bias_sr[31:8]};
                        if (byte_cnt[1:0] == 2'd3) begin
                            bias_data_we   <= 1'b1;
                            bias_data_addr <= byte_cnt[BA_W+1:2];
                            bias_data_in   <= {s_data, bias_sr[31:8]};
                        end
                        if (byte_cnt == B_LAST) begin
                            byte_cnt <= '0;
                            state    <= LOAD_I;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                LOAD_I: begin
                    if (accept) begin
                        input_data_we   <= 1'b1;
                        input_data_addr <= byte_cnt[IA_W-1:0];
                        input_data_in   <= s_data;
                        if (byte_cnt == I_LAST) begin
                            byte_cnt  <= '0;
                            s_ready   <= 1'b0;
                            eng_start <= 1'b1;
                            state     <= START;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                START: begin
                    beat_cnt <= '0;
                    state    <= RUN;
                end

                RUN: begin
                    if (eng_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= eng_result;
                        if (beat_cnt == BEAT_FULL) begin
                            err_count <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                    // Only a fresh rising edge ends the run; a level left over from the last layer does not.
                    if (eng_done && !eng_done_q) begin
                        layer_done <= 1'b1;
                        state      <= FINISH;
                    end
                end

                FINISH: begin
                    if (beat_cnt != BEAT_FULL) begin
                        err_count <= 1'b1;
                    end
                    layer_busy <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
